// File: rtl/conv_pkg.sv
// Shared types, constants and width helper for the conv3x3_stream engine.
package conv_pkg;

    localparam int CONV_COEF_W = 4;

    typedef logic signed [CONV_COEF_W-1:0] coef_t;

    // k8 occupies the MSBs, k0 the LSBs.
    localparam logic [9*CONV_COEF_W-1:0] SHARPEN_COEF = {4'h0, 4'hF, 4'h0,
                                                         4'hF, 4'h5, 4'hF,
                                                         4'h0, 4'hF, 4'h0};
    localparam logic [9*CONV_COEF_W-1:0] BOX_COEF     = {9{4'h1}};

    function automatic int acc_width(input int pix_w, input int coef_w);
        return pix_w + coef_w + 4;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One image line of pixel storage, written and read at the same column address.
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
);

    logic [W-1:0] mem_q [DEPTH];

    // Overwrite the slot after its old value has been read out for the window.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[addr] <= din;
        end
    end

    assign dout = mem_q[addr];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with programmable signed coefficients, shift and clip.
// Optional CONV3X3_ABS_EN adds an abs_mode port for magnitude output.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int COEF_W  = 4,
    parameter int SHIFT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9*COEF_W-1:0]   coef,
    input  logic [SHIFT_W-1:0]    shift,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [PIX_W-1:0]      s_data,
`ifdef CONV3X3_ABS_EN
    input  logic                  abs_mode,
`endif
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [PIX_W-1:0]      m_data,
    output logic                  m_last
);

    localparam int ACC_W = acc_width(PIX_W, COEF_W);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    localparam logic [CW-1:0]             COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]             ROW_LAST = RW'(IMG_H - 1);
    localparam logic signed [ACC_W-1:0]   PIX_MAX  = ACC_W'((1 << PIX_W) - 1);

    logic                     en_s;
    logic                     accept_s;
    logic                     first_s;
    logic                     abs_in_s;
    logic [PIX_W-1:0]         lb0_out_s;
    logic [PIX_W-1:0]         lb1_out_s;
    logic signed [ACC_W-1:0]  mac_s;
    logic signed [ACC_W-1:0]  shifted_s;
    logic signed [ACC_W-1:0]  mag_s;

    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic [9*COEF_W-1:0]      coef_q, coef_d;
    logic [SHIFT_W-1:0]       shift_q, shift_d;
    logic                     abs_q, abs_d;

    logic [8:0][PIX_W-1:0]    win_q, win_d;
    logic                     v0_q, v0_d;
    logic                     last0_q, last0_d;

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     v1_q, v1_d;
    logic                     last1_q, last1_d;
    logic [SHIFT_W-1:0]       sh1_q, sh1_d;
    logic                     abs1_q, abs1_d;

    logic                     m_valid_q, m_valid_d;
    logic [PIX_W-1:0]         m_data_q, m_data_d;
    logic                     m_last_q, m_last_d;

`ifdef CONV3X3_ABS_EN
    assign abs_in_s = abs_mode;
`else
    assign abs_in_s = 1'b0;
`endif

    assign en_s     = !m_valid_q || m_ready;
    assign accept_s = s_valid && en_s;
    assign first_s  = (col_q == '0) && (row_q == '0);

    assign s_ready  = en_s;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;

    // lb0 holds the previous line and feeds lb1, which holds the line before that.
    conv_line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb0 (
        .clk  (clk),
        .en   (accept_s),
        .addr (col_q),
        .din  (s_data),
        .dout (lb0_out_s)
    );

    conv_line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb1 (
        .clk  (clk),
        .en   (accept_s),
        .addr (col_q),
        .din  (lb0_out_s),
        .dout (lb1_out_s)
    );

    function automatic logic signed [ACC_W-1:0] tap(input logic [COEF_W-1:0] k,
                                                    input logic [PIX_W-1:0]  p);
        logic signed [ACC_W-1:0] kx;
        logic signed [ACC_W-1:0] px;
        kx = {{(ACC_W-COEF_W){k[COEF_W-1]}}, k};
        px = {{(ACC_W-PIX_W){1'b0}}, p};
        return kx * px;
    endfunction

    // Raster position counters and frame-start capture of coef/shift/abs.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        coef_d  = coef_q;
        shift_d = shift_q;
        abs_d   = abs_q;
        if (accept_s) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
                row_d = row_q;
            end
            if (first_s) begin
                coef_d  = coef;
                shift_d = shift;
                abs_d   = abs_in_s;
            end else begin
                coef_d  = coef_q;
                shift_d = shift_q;
                abs_d   = abs_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // S0: shift the window one column; index = row*3 + col, row 0 is the oldest line.
    always_comb begin
        win_d   = win_q;
        v0_d    = v0_q;
        last0_d = last0_q;
        if (en_s) begin
            v0_d    = accept_s && (col_q >= CW'(2)) && (row_q >= RW'(2));
            last0_d = accept_s && (col_q == COL_LAST) && (row_q == ROW_LAST);
        end else begin
            v0_d    = v0_q;
            last0_d = last0_q;
        end
        if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3+0] = win_q[r*3+1];
                win_d[r*3+1] = win_q[r*3+2];
            end
            win_d[2] = lb1_out_s;
            win_d[5] = lb0_out_s;
            win_d[8] = s_data;
        end else begin
            win_d = win_q;
        end
    end

    // S1: multiply-accumulate; shift/abs travel with the sum so a new frame cannot alter them.
    always_comb begin
        mac_s = '0;
        for (int i = 0; i < 9; i++) begin
            mac_s = mac_s + tap(coef_q[i*COEF_W +: COEF_W], win_q[i]);
        end
        acc_d   = acc_q;
        v1_d    = v1_q;
        last1_d = last1_q;
        sh1_d   = sh1_q;
        abs1_d  = abs1_q;
        if (en_s) begin
            acc_d   = mac_s;
            v1_d    = v0_q;
            last1_d = last0_q && v0_q;
            sh1_d   = shift_q;
            abs1_d  = abs_q;
        end else begin
            acc_d   = acc_q;
        end
    end

    // S2: arithmetic shift, optional magnitude, then clip into the pixel range.
    always_comb begin
        shifted_s = acc_q >>> sh1_q;
        if (abs1_q && shifted_s[ACC_W-1]) begin
            mag_s = -shifted_s;
        end else begin
            mag_s = shifted_s;
        end
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (en_s) begin
            m_valid_d = v1_q;
            m_last_d  = last1_q && v1_q;
            if (!v1_q) begin
                m_data_d = m_data_q;
            end else if (mag_s[ACC_W-1]) begin
                m_data_d = '0;
            end else if (mag_s > PIX_MAX) begin
                m_data_d = PIX_MAX[PIX_W-1:0];
            end else begin
                m_data_d = mag_s[PIX_W-1:0];
            end
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // State registers; line buffer storage is deliberately left uncleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            coef_q    <= '0;
            shift_q   <= '0;
            abs_q     <= 1'b0;
            win_q     <= '0;
            v0_q      <= 1'b0;
            last0_q   <= 1'b0;
            acc_q     <= '0;
            v1_q      <= 1'b0;
            last1_q   <= 1'b0;
            sh1_q     <= '0;
            abs1_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            coef_q    <= coef_d;
            shift_q   <= shift_d;
            abs_q     <= abs_d;
            win_q     <= win_d;
            v0_q      <= v0_d;
            last0_q   <= last0_d;
            acc_q     <= acc_d;
            v1_q      <= v1_d;
            last1_q   <= last1_d;
            sh1_q     <= sh1_d;
            abs1_q    <= abs1_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed self-checking bench for conv3x3_stream (constant, impulse, box, random+stall, reset).
`timescale 1ns/1ps
module tb_conv3x3_stream;
    import conv_pkg::*;

    localparam int PIX_W   = 8;
    localparam int IMG_W   = 64;
    localparam int IMG_H   = 64;
    localparam int COEF_W  = 4;
    localparam int SHIFT_W = 3;
    localparam int N_PIX   = IMG_W * IMG_H;
    localparam int N_OUT   = (IMG_W - 2) * (IMG_H - 2);

    logic                 clk;
    logic                 rst;
    logic [9*COEF_W-1:0]  coef;
    logic [SHIFT_W-1:0]   shift;
    logic                 s_valid;
    logic                 s_ready;
    logic [PIX_W-1:0]     s_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [PIX_W-1:0]     m_data;
    logic                 m_last;
`ifdef CONV3X3_ABS_EN
    logic                 abs_mode;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int out_data[$];
    int out_last[$];
    int out_cyc[$];
    int unstable = 0;
    bit stall_en = 1'b0;

    int img [N_PIX];
    int tbk [9];
    int tb_shift;
    int frame_mode;
    int cval;
    int imp_r, imp_c, imp_v;
    int acc_cyc;

    conv3x3_stream #(
        .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .COEF_W(COEF_W), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .coef    (coef),
        .shift   (shift),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
`ifdef CONV3X3_ABS_EN
        .abs_mode(abs_mode),
`endif
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Downstream ready: always high, or 5 cycles low / 3 cycles high when stalling.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = stall_en ? ((cyc % 8) >= 5) : 1'b1;
        end
    end

    // Output monitor on the falling edge: record handshakes and check held data during stalls.
    initial begin
        bit         held_v;
        logic [7:0] held_d;
        logic       held_l;
        held_v = 1'b0;
        held_d = 8'd0;
        held_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_valid && m_ready) begin
                    out_data.push_back(int'(m_data));
                    out_last.push_back(int'(m_last));
                    out_cyc.push_back(cyc);
                end
                if (held_v && m_valid && ((m_data != held_d) || (m_last != held_l))) begin
                    unstable++;
                end
                held_v = m_valid && !m_ready;
                held_d = m_data;
                held_l = m_last;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pix(input int r, input int c);
        case (frame_mode)
            0:       return cval;
            1:       return ((r == imp_r) && (c == imp_c)) ? imp_v : 0;
            default: return img[r*IMG_W + c];
        endcase
    endfunction

    function automatic int golden(input int r, input int c);
        int s;
        s = 0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                s += tbk[dr*3 + dc] * img[(r - 1 + dr)*IMG_W + (c - 1 + dc)];
            end
        end
        s = s >>> tb_shift;
        if (s < 0) s = 0;
        else if (s > 255) s = 255;
        return s;
    endfunction

    function automatic int got(input int base, input int r, input int c);
        int idx;
        idx = base + (r - 1)*(IMG_W - 2) + (c - 1);
        return (idx < out_data.size()) ? out_data[idx] : -1;
    endfunction

    task automatic send_pixels(input int count, input bit mid_coef_change);
        for (int i = 0; i < count; i++) begin
            int waited;
            s_valid = 1'b1;
            s_data  = PIX_W'(pix((i / IMG_W) % IMG_H, i % IMG_W));
            waited  = 0;
            forever begin
                @(negedge clk);
                if (s_ready || waited > 64) break;
                waited++;
            end
            @(posedge clk);
            #1;
            if (waited > 64) begin
                chk_eq("accept_timeout", waited, 0);
                break;
            end
            if (i == 130) acc_cyc = cyc;
            if ((i == 0) && mid_coef_change) begin
                coef  = '0;
                shift = '0;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int base);
        int t;
        t = 0;
        while ((out_data.size() < base + N_OUT) && (t < 300)) begin
            @(posedge clk);
            t++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk_eq({tag, "_out_count"}, out_data.size() - base, N_OUT);
    endtask

    // mode 0: every output equals cexp; 1: model; 2: cexp only at centre (10,10), else 0.
    task automatic check_frame(input string tag, input int base, input int mode, input int cexp);
        int bad, lastcnt, last_at, e, r, c;
        bad = 0; lastcnt = 0; last_at = -1;
        for (int i = 0; (i < N_OUT) && (base + i < out_data.size()); i++) begin
            r = i / (IMG_W - 2) + 1;
            c = i % (IMG_W - 2) + 1;
            case (mode)
                0:       e = cexp;
                1:       e = golden(r, c);
                default: e = ((r == 10) && (c == 10)) ? cexp : 0;
            endcase
            if (out_data[base + i] != e) bad++;
            if (out_last[base + i] != 0) begin
                lastcnt++;
                last_at = i;
            end
        end
        chk_eq({tag, "_bad_pixels"}, bad, 0);
        chk_eq({tag, "_last_count"}, lastcnt, 1);
        chk_eq({tag, "_last_index"}, last_at, N_OUT - 1);
    endtask

    task automatic set_tbk_coef();
        for (int i = 0; i < 9; i++) coef[i*COEF_W +: COEF_W] = COEF_W'(tbk[i]);
    endtask

    initial begin
        int base;
        int unst0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; coef = '0; shift = '0;
`ifdef CONV3X3_ABS_EN
        abs_mode = 1'b0;
`endif
        frame_mode = 0; cval = 0; imp_r = 0; imp_c = 0; imp_v = 0; acc_cyc = 0; tb_shift = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_eq("rst_m_valid", int'(m_valid), 0);
        chk_eq("rst_m_data",  int'(m_data),  0);
        chk_eq("rst_m_last",  int'(m_last),  0);
        chk_eq("rst_s_ready", int'(s_ready), 1);

        // Constant 100 with sharpen: every output 100, m_last on the final one.
        base = out_data.size();
        frame_mode = 0; cval = 100; coef = SHARPEN_COEF; shift = 3'd0;
        send_pixels(N_PIX, 1'b0);
        drain("sharp100", base);
        chk_eq("latency", out_cyc[base] - acc_cyc, 2);
        chk_eq("sharp100_first", out_data[base], 100);
        check_frame("sharp100", base, 0, 100);

        // Single 255 at (10,10): centre clips 1275 to 255, 4-neighbours go to 0.
        base = out_data.size();
        frame_mode = 1; imp_r = 10; imp_c = 10; imp_v = 255;
        send_pixels(N_PIX, 1'b0);
        drain("impulse", base);
        chk_eq("imp_c_10_10", got(base, 10, 10), 255);
        chk_eq("imp_n_9_10",  got(base, 9, 10),  0);
        chk_eq("imp_n_10_9",  got(base, 10, 9),  0);
        chk_eq("imp_n_11_10", got(base, 11, 10), 0);
        chk_eq("imp_n_10_11", got(base, 10, 11), 0);
        check_frame("impulse", base, 2, 255);

        // Box over 80 with shift 3 gives 90; coef/shift are zeroed after the first accept.
        base = out_data.size();
        frame_mode = 0; cval = 80; coef = BOX_COEF; shift = 3'd3;
        send_pixels(N_PIX, 1'b1);
        drain("box80", base);
        check_frame("box80", base, 0, 90);

        // Random frame with asymmetric kernel, free-running then stalled.
        for (int i = 0; i < N_PIX; i++) img[i] = int'($urandom_range(255, 0));
        tbk[0] = 1;  tbk[1] = 2; tbk[2] = -3;
        tbk[3] = 0;  tbk[4] = 4; tbk[5] = -1;
        tbk[6] = -2; tbk[7] = 3; tbk[8] = -8;
        tb_shift = 1;
        frame_mode = 2;
        base = out_data.size();
        set_tbk_coef(); shift = 3'd1;
        send_pixels(N_PIX, 1'b0);
        drain("rand_free", base);
        check_frame("rand_free", base, 1, 0);

        base = out_data.size();
        unst0 = unstable;
        set_tbk_coef(); shift = 3'd1;
        stall_en = 1'b1;
        send_pixels(N_PIX, 1'b0);
        drain("rand_stall", base);
        stall_en = 1'b0;
        check_frame("rand_stall", base, 1, 0);
        chk_eq("stall_unstable", unstable - unst0, 0);

        // Reset mid-frame after 1000 accepts, then a clean constant-50 frame.
        coef = SHARPEN_COEF; shift = 3'd0;
        send_pixels(1000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("midrst_m_valid", int'(m_valid), 0);
        rst = 1'b0;
        base = out_data.size();
        frame_mode = 0; cval = 50;
        send_pixels(N_PIX, 1'b0);
        drain("post_rst50", base);
        check_frame("post_rst50", base, 0, 50);

`ifdef CONV3X3_ABS_EN
        // Magnitude mode: -50 neighbours become 50, centre 5*50 = 250.
        base = out_data.size();
        abs_mode = 1'b1;
        frame_mode = 1; imp_r = 10; imp_c = 10; imp_v = 50;
        coef = SHARPEN_COEF; shift = 3'd0;
        send_pixels(N_PIX, 1'b0);
        abs_mode = 1'b0;
        drain("abs", base);
        chk_eq("abs_9_10",  got(base, 9, 10),  50);
        chk_eq("abs_10_9",  got(base, 10, 9),  50);
        chk_eq("abs_10_10", got(base, 10, 10), 250);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Streaming, parametrised 3×3 convolution engine for raster-order pixel streams, and the successor to the fixed-coefficient combinational kernels in the image pipeline. It owns its own line buffers and window registers. It takes runtime-programmable signed coefficients with a post-scale shift, clips results to the pixel range, and moves data with valid/ready handshakes on both sides. It sits between the frame source and the output frame store, and instances can be chained back-to-back.

## Interface
- PIX_W, 8, pixel width in bits (unsigned)
- IMG_W, 64, input image width in pixels (≥3)
- IMG_H, 64, input image height in lines (≥3)
- COEF_W, 4, signed coefficient width
- SHIFT_W, 3, width of the right-shift amount
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- coef  in  9*COEF_W  signed coefficients, k0 in LSBs, raster order k0..k8
- shift  in  SHIFT_W  arithmetic right shift applied to the sum
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_data  in  PIX_W  input pixel
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  PIX_W  output pixel
- m_last  out  1  marks the final output pixel of a frame

## Operation
- Input is raster order; a frame is exactly IMG_W*IMG_H accepted pixels. Internal col/row counters advance on each accept. At col=IMG_W-1 the counter wraps to 0 and row increments. At the last pixel of the frame both counters wrap to 0.
- coef and shift are latched into internal registers when the pixel at row 0, col 0 is accepted. They stay constant for the whole frame, so mid-frame changes on the ports are ignored.
- Two conv_line_buf instances, each IMG_W deep, hold the previous two lines. A 3×3 window register shifts one column per accept.
- Window output: a window is emitted when the accepted pixel has col≥2 and row≥2. It is centred on (row-1, col-1). This gives (IMG_W-2)*(IMG_H-2) outputs per frame with no border padding.
- Arithmetic:
  - Pixels are zero-extended.
  - sum = Σ k_i·p_i, held in a signed accumulator of PIX_W+COEF_W+4 bits, which cannot overflow.
  - The sum is arithmetic-shifted right by the latched shift.
  - The result is clipped: values <0 become 0, and values >2^PIX_W-1 become 2^PIX_W-1.
- m_last is asserted with the output for window centre (IMG_H-2, IMG_W-2).
- Line-buffer contents are never cleared. Rows 0–1 of each frame never produce outputs, so stale data cannot reach the output.

## Timing
- Pipeline stages:
  - S0: accept, which updates the line buffers and window.
  - S1: multiply-accumulate register.
  - S2: shift/clip output register.
- Global enable en = !m_valid || m_ready. s_ready = en, combinationally.
- Latency: an accept on edge N that completes a window gives m_valid=1 after edge N+2 when not stalled.
- Stall: while m_valid && !m_ready, all stages hold and m_data/m_last stay stable. Stalls cause no loss and no duplication.
- Throughput is one pixel per cycle when m_ready is held high.
- Reset values:
  - m_valid=0, m_data=0, m_last=0.
  - Counters are 0, and the coef/shift registers are 0.
  - s_ready=1 in the first cycle after reset.
- Reset mid-frame discards in-flight outputs. The next accepted pixel is treated as row 0, col 0.
- Simultaneous accept and output handshake in the same cycle is legal and is the normal streaming case.

## Configuration
- CONV3X3_ABS_EN defined:
  - Adds port abs_mode (in, 1). It is latched with coef at frame start.
  - When abs_mode=1, the result is min(|sum>>shift|, 2^PIX_W-1), for edge-magnitude filters.
  - When abs_mode=0, clipping behaves as normal.
- Not defined: the port is absent and only the clip-to-zero behaviour exists.

## Structure
- Package conv_pkg:
  - coefficient typedef (signed [COEF_W-1:0]) and accumulator-width function.
  - constant SHARPEN_COEF = {0,-1,0,-1,5,-1,0,-1,0}.
  - constant BOX_COEF = all 1.
- Sub-module conv_line_buf: IMG_W-deep, PIX_W-wide circular buffer with an enable-gated write/read at a shared address (col). It is instantiated twice and chained.

## Test plan
- 64×64 constant frame of 100, SHARPEN_COEF, shift 0:
  - 3844 outputs, all 100.
  - m_last only on output 3844.
- Frame of zeros with 255 at (10,10), SHARPEN_COEF:
  - output at centre (10,10) = 255 (clipped from 1275).
  - outputs at (9,10), (10,9), (11,10) and (10,11) = 0.
  - all other outputs = 0.
- Constant frame of 80, BOX_COEF, shift 3: every output = 90 (720>>3).
- Random frame with m_ready toggling (low 5 cycles, high 3): output sequence identical to the m_ready=1 run, and m_data stays stable during stalls.
- rst asserted after 1000 accepts, then a fresh constant-50 frame: m_valid=0 after the reset edge, then 3844 outputs of 50.
- CONV3X3_ABS_EN, abs_mode=1, SHARPEN_COEF, single 50 at (10,10): output (9,10) = 50 and (10,10) = 250.
